// File: rtl/fp_dot_sequencer_if.sv
// Bundle of the sequencer's control, operand-buffer and MAC-slave signals.
// The master modport is the sequencer; the slave modport is its environment.
interface fp_dot_sequencer_if #(
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  length;
    logic [DATA_WIDTH-1:0] init_acc;
    logic                  fifo_a_empty;
    logic                  fifo_a_rd_en;
    logic [DATA_WIDTH-1:0] fifo_a_data;
    logic                  fifo_b_empty;
    logic                  fifo_b_rd_en;
    logic [DATA_WIDTH-1:0] fifo_b_data;
    logic [2:0]            mac_address;
    logic                  mac_write;
    logic [DATA_WIDTH-1:0] mac_writedata;
    logic                  mac_read;
    logic [DATA_WIDTH-1:0] mac_readdata;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] result;
    logic [LEN_WIDTH-1:0]  elem_count;

    modport master (
        input  start, length, init_acc,
        input  fifo_a_empty, fifo_a_data, fifo_b_empty, fifo_b_data, mac_readdata,
        output fifo_a_rd_en, fifo_b_rd_en,
        output mac_address, mac_write, mac_writedata, mac_read,
        output busy, done, result, elem_count
    );

    modport slave (
        output start, length, init_acc,
        output fifo_a_empty, fifo_a_data, fifo_b_empty, fifo_b_data, mac_readdata,
        input  fifo_a_rd_en, fifo_b_rd_en,
        input  mac_address, mac_write, mac_writedata, mac_read,
        input  busy, done, result, elem_count
    );
endinterface

// File: rtl/fp_dot_sequencer.sv
// Dot-product sequencer: pops A/B operand pairs and drives the FP MAC slave
// (write A, write B, write accumulator, read result) once per element.
module fp_dot_sequencer #(
    parameter int LEN_WIDTH  = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    fp_dot_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_CAPTURE = 4'd2,
        S_WR_A    = 4'd3,
        S_WR_B    = 4'd4,
        S_WR_C    = 4'd5,
        S_RD      = 4'd6,
        S_LATCH   = 4'd7,
        S_DONE    = 4'd8
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] acc_r, acc_s;
    logic [DATA_WIDTH-1:0] op_a_r, op_a_s;
    logic [DATA_WIDTH-1:0] op_b_r, op_b_s;
    logic [DATA_WIDTH-1:0] result_r, result_s;
    logic [LEN_WIDTH-1:0]  len_r, len_s;
    logic [LEN_WIDTH-1:0]  count_r, count_s;
    logic [LEN_WIDTH:0]    count_inc_s;
    logic                  accept_s;

    logic                  rd_en_r, rd_en_s;
    logic [2:0]            addr_r, addr_s;
    logic                  write_r, write_s;
    logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
    logic                  read_r, read_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;

    assign accept_s    = (state_r == S_IDLE) && bus.start;
    assign count_inc_s = {1'b0, count_r} + {{LEN_WIDTH{1'b0}}, 1'b1};

    // Next-state selection.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_s = (bus.length == {LEN_WIDTH{1'b0}}) ? S_DONE : S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            // The pop pulse is issued from a registered look-ahead of the
            // empty flags; only this block pops, so they cannot change under it.
            S_FETCH:   state_s = rd_en_r ? S_CAPTURE : S_FETCH;
            S_CAPTURE: state_s = S_WR_A;
            S_WR_A:    state_s = S_WR_B;
            S_WR_B:    state_s = S_WR_C;
            S_WR_C:    state_s = S_RD;
            S_RD:      state_s = S_LATCH;
            S_LATCH: begin
                if (count_inc_s == {1'b0, len_r}) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DONE:    state_s = S_IDLE;
            default:   state_s = S_IDLE;
        endcase
    end

    // Datapath next values.
    always_comb begin
        len_s   = len_r;
        acc_s   = acc_r;
        op_a_s  = op_a_r;
        op_b_s  = op_b_r;
        count_s = count_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    len_s   = bus.length;
                    acc_s   = bus.init_acc;
                    count_s = {LEN_WIDTH{1'b0}};
                end else begin
                    len_s   = len_r;
                end
            end
            S_CAPTURE: begin
                op_a_s = bus.fifo_a_data;
                op_b_s = bus.fifo_b_data;
            end
            S_LATCH: begin
                acc_s   = bus.mac_readdata;
                count_s = count_inc_s[LEN_WIDTH-1:0];
            end
            default: begin
                count_s = count_r;
            end
        endcase
        if (state_s == S_DONE) begin
            result_s = acc_s;
        end else if (accept_s) begin
            result_s = {DATA_WIDTH{1'b0}};
        end else begin
            result_s = result_r;
        end
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        rd_en_s = 1'b0;
        addr_s  = 3'd0;
        write_s = 1'b0;
        wdata_s = {DATA_WIDTH{1'b0}};
        read_s  = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
        case (state_s)
            S_FETCH: begin
                busy_s  = 1'b1;
                rd_en_s = !bus.fifo_a_empty && !bus.fifo_b_empty;
            end
            S_CAPTURE: busy_s = 1'b1;
            S_WR_A: begin
                busy_s  = 1'b1;
                write_s = 1'b1;
                addr_s  = 3'd0;
                wdata_s = op_a_s;
            end
            S_WR_B: begin
                busy_s  = 1'b1;
                write_s = 1'b1;
                addr_s  = 3'd1;
                wdata_s = op_b_s;
            end
            S_WR_C: begin
                busy_s  = 1'b1;
                write_s = 1'b1;
                addr_s  = 3'd2;
                wdata_s = acc_s;
            end
            S_RD: begin
                busy_s = 1'b1;
                read_s = 1'b1;
            end
            S_LATCH:  busy_s = 1'b1;
            S_DONE:   done_s = 1'b1;
            default:  busy_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r    <= {LEN_WIDTH{1'b0}};
            acc_r    <= {DATA_WIDTH{1'b0}};
            op_a_r   <= {DATA_WIDTH{1'b0}};
            op_b_r   <= {DATA_WIDTH{1'b0}};
            count_r  <= {LEN_WIDTH{1'b0}};
            result_r <= {DATA_WIDTH{1'b0}};
        end else begin
            len_r    <= len_s;
            acc_r    <= acc_s;
            op_a_r   <= op_a_s;
            op_b_r   <= op_b_s;
            count_r  <= count_s;
            result_r <= result_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en_r <= 1'b0;
            addr_r  <= 3'd0;
            write_r <= 1'b0;
            wdata_r <= {DATA_WIDTH{1'b0}};
            read_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            rd_en_r <= rd_en_s;
            addr_r  <= addr_s;
            write_r <= write_s;
            wdata_r <= wdata_s;
            read_r  <= read_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.fifo_a_rd_en  = rd_en_r;
    assign bus.fifo_b_rd_en  = rd_en_r;
    assign bus.mac_address   = addr_r;
    assign bus.mac_write     = write_r;
    assign bus.mac_writedata = wdata_r;
    assign bus.mac_read      = read_r;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.result        = result_r;
    assign bus.elem_count    = count_r;

endmodule

// File: tb/tb_fp_dot_sequencer.sv
// Self-checking bench for fp_dot_sequencer: behavioural operand buffers and
// FP MAC slave, with a fold-style dot-product reference model.
module tb_fp_dot_sequencer;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   pops = 0;

    always #5 clk = ~clk;

    fp_dot_sequencer_if #(.LEN_WIDTH(LW), .DATA_WIDTH(32)) bus ();
    fp_dot_sequencer #(.LEN_WIDTH(LW), .DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic real from_f32(input logic [31:0] f);
        real r;
        int  e;
        if (f[30:23] == 8'd0) return 0.0;
        r = 1.0 + real'(f[22:0]) / 8388608.0;
        e = int'(f[30:23]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return f[31] ? -r : r;
    endfunction

    function automatic logic [31:0] to_f32(input real x);
        real         m;
        int          e;
        logic        s;
        logic [22:0] man;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        man = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e + 127), man};
    endfunction

    // FP MAC slave behaviour: a*b+c, NaN/Inf operands pass through unchanged.
    function automatic logic [31:0] mac_fn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        if (c[30:23] == 8'hFF) return c;
        if (a[30:23] == 8'hFF) return a;
        if (b[30:23] == 8'hFF) return b;
        return to_f32(from_f32(a) * from_f32(b) + from_f32(c));
    endfunction

    function automatic logic [31:0] rand_f32();
        return to_f32(real'(int'($urandom_range(0, 32)) - 16) * 0.25);
    endfunction

    // Operand buffers.
    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];
    int a_wr = 0, a_rd = 0, b_wr = 0, b_rd = 0;
    assign bus.fifo_a_empty = (a_wr == a_rd);
    assign bus.fifo_b_empty = (b_wr == b_rd);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            a_rd <= a_wr;
            b_rd <= b_wr;
        end else begin
            if (bus.fifo_a_rd_en) begin
                bus.fifo_a_data <= a_mem[a_rd % 256];
                a_rd <= a_rd + 1;
            end
            if (bus.fifo_b_rd_en) begin
                bus.fifo_b_data <= b_mem[b_rd % 256];
                b_rd <= b_rd + 1;
            end
        end
    end

    // MAC slave register file.
    logic [31:0] mreg [3];
    always @(posedge clk) begin
        if (bus.mac_write && bus.mac_address < 3'd3) mreg[bus.mac_address[1:0]] <= bus.mac_writedata;
        if (bus.mac_read) bus.mac_readdata <= mac_fn(mreg[0], mreg[1], mreg[2]);
    end

    // Bus monitor: logs MAC traffic and checks bus invariants every cycle.
    logic [35:0] log_q[$];
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("rd_en_pair", 64'(bus.fifo_a_rd_en), 64'(bus.fifo_b_rd_en));
            if (!bus.mac_write) check_eq("wdata_idle", 64'(bus.mac_writedata), 64'h0);
            if (!bus.mac_write && !bus.mac_read) check_eq("addr_idle", 64'(bus.mac_address), 64'h0);
            if (bus.mac_write) log_q.push_back({1'b0, bus.mac_address, bus.mac_writedata});
            if (bus.mac_read) log_q.push_back({1'b1, bus.mac_address, 32'h0});
            if (bus.fifo_a_rd_en) begin
                pops++;
                check_eq("pop_nonempty", 64'({bus.fifo_a_empty, bus.fifo_b_empty}), 64'h0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ctl"}, 64'({bus.fifo_a_rd_en, bus.fifo_b_rd_en, bus.mac_address, bus.mac_write,
                                      bus.mac_read, bus.busy, bus.done, bus.elem_count}), 64'h0);
        check_eq({tag, "_data"}, {bus.mac_writedata, bus.result}, 64'h0);
    endtask

    task automatic run_dot(input string tag, input int len, input logic [31:0] init,
                           input logic [31:0] av[$], input logic [31:0] bv[$], input int stall_b);
        logic [31:0] acc;
        logic [35:0] exp_log[$];
        int e0, n, p0;
        acc = init;
        for (int i = 0; i < len; i++) begin
            exp_log.push_back({1'b0, 3'd0, av[i]});
            exp_log.push_back({1'b0, 3'd1, bv[i]});
            exp_log.push_back({1'b0, 3'd2, acc});
            exp_log.push_back({1'b1, 3'd0, 32'h0});
            acc = mac_fn(av[i], bv[i], acc);
        end
        for (int i = 0; i < len; i++) begin
            a_mem[a_wr % 256] = av[i];
            a_wr++;
            if (stall_b == 0) begin
                b_mem[b_wr % 256] = bv[i];
                b_wr++;
            end
        end
        @(negedge clk);
        log_q.delete();
        p0 = pops;
        bus.start = 1'b1;
        bus.length = LW'(len);
        bus.init_acc = init;
        @(negedge clk);
        bus.start = 1'b0;
        bus.length = LW'($urandom);
        bus.init_acc = $urandom;
        e0 = cyc;
        n = 0;
        while (!bus.done && n < 3000) begin
            if (stall_b > 0 && n == stall_b / 2) begin
                bus.start = 1'b1;
                bus.length = 8'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (stall_b > 0 && n == stall_b) begin
                check_eq({tag, "_stall_nopop"}, 64'(pops - p0), 64'h0);
                check_eq({tag, "_stall_busy"}, 64'(bus.busy), 64'h1);
                for (int i = 0; i < len; i++) begin
                    b_mem[b_wr % 256] = bv[i];
                    b_wr++;
                end
            end
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check_eq({tag, "_done"}, 64'(bus.done), 64'h1);
        if (stall_b == 0) check_eq({tag, "_latency"}, 64'(cyc - e0), 64'(7 * len));
        else check_eq({tag, "_latency_min"}, 64'((cyc - e0) >= 7 * len + stall_b), 64'h1);
        check_eq({tag, "_result"}, 64'(bus.result), 64'(acc));
        check_eq({tag, "_count"}, 64'(bus.elem_count), 64'(len));
        check_eq({tag, "_busy_at_done"}, 64'(bus.busy), 64'h0);
        check_eq({tag, "_pops"}, 64'(pops - p0), 64'(len));
        check_eq({tag, "_log_len"}, 64'(log_q.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            check_eq({tag, "_mac_seq"}, 64'(log_q[i]), 64'(exp_log[i]));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 64'(bus.done), 64'h0);
        check_eq({tag, "_result_hold"}, 64'(bus.result), 64'(acc));
    endtask

    initial begin
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        int len, stall, n;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.length = '0;
        bus.init_acc = '0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        qa = '{32'h3F800000, 32'h40000000};
        qb = '{32'h40400000, 32'h40800000};
        run_dot("len2", 2, 32'h0, qa, qb, 0);
        check_eq("len2_value", 64'(bus.result), 64'h41300000);

        qa = '{32'h40000000};
        qb = '{32'h40000000};
        run_dot("len1", 1, 32'h3F000000, qa, qb, 0);
        check_eq("len1_value", 64'(bus.result), 64'h40900000);

        qa.delete();
        qb.delete();
        run_dot("len0", 0, 32'h12345678, qa, qb, 0);
        check_eq("len0_value", 64'(bus.result), 64'h12345678);

        qa = '{32'h40400000};
        qb = '{32'h40400000};
        run_dot("stall_b", 1, 32'h3F800000, qa, qb, 10);

        qa = '{32'h7FC12345, 32'h3F800000};
        qb = '{32'h3F800000, 32'h3F800000};
        run_dot("nan", 2, 32'h0, qa, qb, 0);
        check_eq("nan_value", 64'(bus.result), 64'h7FC12345);

        // Reset in the middle of a three-element run.
        qa = '{32'h3F800000, 32'h3F800000, 32'h3F800000};
        for (int i = 0; i < 3; i++) begin
            a_mem[a_wr % 256] = qa[i]; a_wr++;
            b_mem[b_wr % 256] = qa[i]; b_wr++;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.length = 8'd3;
        bus.init_acc = 32'h0;
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.mac_write && bus.mac_address == 3'd1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("midrst_reach_wr_b", 64'(bus.mac_write && bus.mac_address == 3'd1), 64'h1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("midrst_after");
        qa = '{32'h40400000};
        qb = '{32'h40000000};
        run_dot("post_rst", 1, 32'h3F800000, qa, qb, 0);
        check_eq("post_rst_value", 64'(bus.result), 64'h40E00000);

        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(0, 6);
            stall = ($urandom_range(0, 3) == 0 && len > 0) ? $urandom_range(1, 6) : 0;
            qa.delete();
            qb.delete();
            for (int i = 0; i < len; i++) begin
                qa.push_back(rand_f32());
                qb.push_back(rand_f32());
            end
            run_dot("rand", len, rand_f32(), qa, qb, stall);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
